// File: rtl/loop_sel_driver_if.sv
// Request/select bundle between a controller (master) and loop_sel_driver (slave).
interface loop_sel_driver_if #(
    parameter int DT_W = 4
);
    logic            req_valid;
    logic [2:0]      req_code;
    logic            req_ready;
    logic [DT_W-1:0] dt_cfg;
    logic [3:0]      sel;
    logic            idle;
    logic            done;
    logic            err;

    modport master (
        output req_valid, req_code, dt_cfg,
        input  req_ready, sel, idle, done, err
    );

    modport slave (
        input  req_valid, req_code, dt_cfg,
        output req_ready, sel, idle, done, err
    );
endinterface

// File: rtl/loop_sel_driver.sv
// Break-before-make driver for four one-hot select lines with a programmable dead time.
// Define LOOP_SEL_DEADTIME_EN for a dt_cfg-driven dead time; otherwise the dead time is fixed at one cycle.
module loop_sel_driver #(
    parameter int DT_W = 4
) (
    input  logic               CELCLK,
    input  logic               CELRST,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    loop_sel_driver_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BREAK = 2'd1;
    localparam logic [1:0] ST_MAKE  = 2'd2;

    logic [1:0] state;
    logic [2:0] code_q;
    logic [3:0] sel_q;
    logic       idle_q;
    logic       done_q;
    logic       err_q;
    logic       accept;
    logic       is_switch;
    logic       break_last;

    // Supply and substrate pins exist only for the physical brick.
    logic unused_pins;
    assign unused_pins = &{1'b0, CELV, CELG, SUB};

    function automatic logic [3:0] onehot(input logic [2:0] code);
        case (code)
            3'd1:    onehot = 4'b0001;
            3'd2:    onehot = 4'b0010;
            3'd3:    onehot = 4'b0100;
            3'd4:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    endfunction

    assign bus.req_ready = (state == ST_IDLE) && !CELRST;
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_switch     = accept && (bus.req_code <= 3'd4) && (bus.req_code != code_q);

`ifdef LOOP_SEL_DEADTIME_EN
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_load;

    // Counter is loaded with D-1 so that BREAK spans exactly D cycles; dt_cfg = 0 behaves as 1.
    assign cnt_load   = (bus.dt_cfg == '0) ? '0 : bus.dt_cfg - DT_W'(1);
    assign break_last = (cnt == '0);

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            cnt <= '0;
        end else if (is_switch) begin
            cnt <= cnt_load;
        end else if (state == ST_BREAK && cnt != '0) begin
            cnt <= cnt - DT_W'(1);
        end
    end
`else
    logic unused_dt;
    assign unused_dt  = &{1'b0, bus.dt_cfg};
    assign break_last = 1'b1;
`endif

    // sel and idle always change together so idle is the registered NOR of sel.
    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            state  <= ST_IDLE;
            code_q <= 3'd0;
            sel_q  <= 4'b0000;
            idle_q <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.req_code > 3'd4) begin
                            err_q <= 1'b1;
                        end else if (bus.req_code == code_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_BREAK;
                            code_q <= bus.req_code;
                            sel_q  <= 4'b0000;
                            idle_q <= 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (break_last) begin
                        state  <= ST_MAKE;
                        sel_q  <= onehot(code_q);
                        idle_q <= (code_q == 3'd0) || (code_q > 3'd4);
                        done_q <= 1'b1;
                    end
                end
                ST_MAKE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel  = sel_q;
    assign bus.idle = idle_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_loop_sel_driver.sv
// Directed bench for loop_sel_driver; expected dead time follows LOOP_SEL_DEADTIME_EN.
module tb_loop_sel_driver;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    loop_sel_driver_if #(.DT_W(4)) bus ();

    loop_sel_driver #(.DT_W(4)) dut (
        .CELCLK (clk),
        .CELRST (rst),
        .CELV   (1'b1),
        .CELG   (1'b0),
        .SUB    (1'b0),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {sel[3:0], idle, done, err, req_ready}
    logic [7:0] obs;
    assign obs = {bus.sel, bus.idle, bus.done, bus.err, bus.req_ready};

    function automatic int dexp(input int dt);
`ifdef LOOP_SEL_DEADTIME_EN
        return (dt == 0) ? 1 : dt;
`else
        return 1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_code  = 3'd0;
        bus.dt_cfg    = 4'd0;
        step();
        step();
        checks++;
        if (obs !== 8'b0000_1_0_0_0) begin
            failures++;
            $display("[TB] FAIL reset_state got=%b expected=%b", obs, 8'b0000_1_0_0_0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b0000_1_0_0_1) begin
            failures++;
            $display("[TB] FAIL reset_release got=%b expected=%b", obs, 8'b0000_1_0_0_1);
        end
    endtask

    // Switch from the current selection to a different legal code, checking every cycle.
    task automatic test_switch(input logic [2:0] code, input logic [3:0] dt,
                               input logic [3:0] exp_sel, input logic hold_busy_req);
        int d;
        d = dexp(int'(dt));
        bus.req_valid = 1'b1;
        bus.req_code  = code;
        bus.dt_cfg    = dt;
        step();
        bus.dt_cfg    = 4'd15;
        bus.req_valid = hold_busy_req;
        bus.req_code  = 3'd1;
        for (int i = 0; i < d; i++) begin
            checks++;
            if (obs !== 8'b0000_1_0_0_0) begin
                failures++;
                $display("[TB] FAIL break_c%0d_cyc%0d got=%b expected=%b", code, i, obs, 8'b0000_1_0_0_0);
            end
            step();
        end
        checks++;
        if (obs !== {exp_sel, exp_sel == 4'b0000, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL make_c%0d got=%b expected=%b", code, obs,
                     {exp_sel, exp_sel == 4'b0000, 1'b1, 1'b0, 1'b0});
        end
        bus.req_valid = 1'b0;
        step();
        checks++;
        if (obs !== {exp_sel, exp_sel == 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL after_make_c%0d got=%b expected=%b", code, obs,
                     {exp_sel, exp_sel == 4'b0000, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_same_code(input logic [2:0] code, input logic [3:0] cur_sel);
        bus.req_valid = 1'b1;
        bus.req_code  = code;
        bus.dt_cfg    = 4'd3;
        step();
        bus.req_valid = 1'b0;
        checks++;
        if (obs !== {cur_sel, cur_sel == 4'b0000, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL same_code_done got=%b expected=%b", obs, {cur_sel, cur_sel == 4'b0000, 1'b1, 1'b0, 1'b1});
        end
        step();
        checks++;
        if (obs !== {cur_sel, cur_sel == 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL same_code_hold got=%b expected=%b", obs, {cur_sel, cur_sel == 4'b0000, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_illegal(input logic [3:0] cur_sel);
        for (int c = 5; c < 8; c++) begin
            bus.req_valid = 1'b1;
            bus.req_code  = 3'(c);
            step();
            bus.req_valid = 1'b0;
            checks++;
            if (obs !== {cur_sel, 1'b0, 1'b0, 1'b1, 1'b1}) begin
                failures++;
                $display("[TB] FAIL illegal_%0d_err got=%b expected=%b", c, obs, {cur_sel, 1'b0, 1'b0, 1'b1, 1'b1});
            end
            step();
            checks++;
            if (obs !== {cur_sel, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("[TB] FAIL illegal_%0d_clear got=%b expected=%b", c, obs, {cur_sel, 1'b0, 1'b0, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_reset_mid_break();
        bus.req_valid = 1'b1;
        bus.req_code  = 3'd2;
        bus.dt_cfg    = 4'd5;
        step();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b0000_1_0_0_1) begin
            failures++;
            $display("[TB] FAIL midbreak_reset got=%b expected=%b", obs, 8'b0000_1_0_0_1);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs !== 8'b0000_1_0_0_1) begin
                failures++;
                $display("[TB] FAIL midbreak_quiet_%0d got=%b expected=%b", i, obs, 8'b0000_1_0_0_1);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_switch(3'd2, 4'd3, 4'b0010, 1'b0);
        test_same_code(3'd2, 4'b0010);
        test_illegal(4'b0010);
        test_same_code(3'd2, 4'b0010);
        test_switch(3'd1, 4'd0, 4'b0001, 1'b0);
        test_switch(3'd4, 4'd0, 4'b1000, 1'b0);
        test_switch(3'd3, 4'd9, 4'b0100, 1'b1);
        test_switch(3'd0, 4'd2, 4'b0000, 1'b0);
        test_same_code(3'd0, 4'b0000);
        test_switch(3'd3, 4'd1, 4'b0100, 1'b0);
        test_reset_mid_break();
        test_same_code(3'd0, 4'b0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/loop_sel_driver.md
LOOP_SEL_DRIVER -- requirements
Module: loop_sel_driver

Interface
REQ-001 Parameter: DT_W, default 4, width of the dead-time configuration field and of the dead-time counter.
REQ-002 Port: CELCLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: CELRST, input, 1, reset; synchronous, active-high.
REQ-004 Port: CELV, input, 1, brick supply pin; no functional effect.
REQ-005 Port: CELG, input, 1, brick ground pin; no functional effect.
REQ-006 Port: SUB, input, 1, substrate pin; no functional effect.
REQ-007 Port: req_valid, input, 1, a selection request is present.
REQ-008 Port: req_code, input, 3, requested selection: 0 = all lines off; 1..4 = drive sel[0..3]; 5..7 = illegal.
REQ-009 Port: req_ready, output, 1, the block can accept a request this cycle.
REQ-010 Port: dt_cfg, input, DT_W, dead-time length in cycles.
REQ-011 Port: sel, output, 4, one-hot-or-zero select lines feeding the downstream nor4 idle detector.
REQ-012 Port: idle, output, 1, registered, high when sel == 0.
REQ-013 Port: done, output, 1, one-cycle pulse when a switch completes.
REQ-014 Port: err, output, 1, one-cycle pulse when an illegal code is accepted.

Function
REQ-015 The FSM SHALL have three states: IDLE, BREAK and MAKE.
REQ-016 req_ready SHALL be 1 only in IDLE and only when CELRST is low.
REQ-017 A request SHALL be accepted in any cycle T where req_valid and req_ready are both 1.
REQ-018 Illegal code accepted at T: err = 1 at T+1; sel unchanged; FSM stays in IDLE; done stays 0.
REQ-019 Code equal to current selection accepted at T: done = 1 at T+1; sel unchanged; no BREAK.
REQ-020 Any other legal code accepted at T: go to BREAK; sel = 0 and idle = 1 from T+1; code and dead time latched at T.
REQ-021 BREAK SHALL last D cycles, with D = max(dt_cfg, 1); dt_cfg changes after T SHALL be ignored.
REQ-022 MAKE SHALL last exactly one cycle, in which sel takes the one-hot value of the latched code and done = 1; FSM then returns to IDLE.
REQ-023 For code 0, sel SHALL remain 0 through MAKE.
REQ-024 Timing for a switch accepted at T: new sel and done both at T+1+D; next request acceptable at T+2+D.
REQ-025 sel SHALL never have more than one bit set, and SHALL never switch directly between two nonzero values.
REQ-026 idle SHALL equal the NOR of sel in the same cycle (registered alongside sel).
REQ-027 req_valid while req_ready = 0 SHALL be ignored; no request is queued.

Reset
REQ-028 With CELRST high at an edge: state = IDLE, sel = 0, idle = 1, done = 0, err = 0, counter = 0, latched code = 0.
REQ-029 CELRST asserted during BREAK or MAKE SHALL abort the switch; no done pulse is generated.

Configuration
REQ-030 Macro LOOP_SEL_DEADTIME_EN defined: D = max(dt_cfg, 1), using a DT_W-bit down-counter.
REQ-031 Macro LOOP_SEL_DEADTIME_EN undefined: the dt_cfg port remains, is ignored, and D = 1 fixed; no counter is built.

Verification
REQ-032 Reset, then code 2 accepted at T with dt_cfg = 3: sel = 0000 for T+1..T+3; sel = 0010 and done = 1 at T+4; req_ready = 1 at T+5.
REQ-033 From sel = 0010, code 2 accepted at T: done at T+1; sel holds 0010 with no glitch.
REQ-034 Code 6 accepted: err = 1 for exactly one cycle; sel and state unchanged.
REQ-035 With dt_cfg = 0, switch from code 1 to code 4: exactly one zero cycle, then sel = 1000.
REQ-036 CELRST pulsed mid-BREAK: the next edge gives sel = 0, idle = 1, req_ready = 1, and no done pulse.
REQ-037 Build without LOOP_SEL_DEADTIME_EN, dt_cfg = 9: BREAK lasts 1 cycle.
